ballot_unit_ctrl: RTL and testbench



---
 rtl/evm_pkg.sv | 24 ++
 rtl/btn_sync_debounce.sv | 38 +++
 rtl/ballot_unit_ctrl.sv | 143 ++++++++++++++
 tb/tb_ballot_unit_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared definitions for the EVM front end: controller states, party codes
// and the default ballot limit.
package evm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAST,
        RELEASE_WAIT,
        CLOSED
    } ballot_state_t;

    localparam logic [2:0] PARTY1 = 3'b001;
    localparam logic [2:0] PARTY2 = 3'b010;
    localparam logic [2:0] PARTY3 = 3'b100;

    // Matches the 7-bit party counters downstream.
    localparam int DEFAULT_MAX_BALLOTS = 127;

    function automatic logic is_one_hot(input logic [2:0] v);
        return (v == PARTY1) || (v == PARTY2) || (v == PARTY3);
    endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchronizer for a raw button vector plus a stability counter that
// flags the synced vector once it has held still for DEBOUNCE_CYCLES cycles.
module btn_sync_debounce #(
    parameter int W               = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] btn_raw,
    output logic [W-1:0] sync_vec,
    output logic         stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [W-1:0]     sync_s1;
    logic [CNT_W-1:0] stab_cnt;

    // sync_s1 is next cycle's synced value, so a difference means the synced
    // vector is changing at this edge and the count restarts with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1  <= '0;
            sync_vec <= '0;
            stab_cnt <= '0;
        end else begin
            sync_s1  <= btn_raw;
            sync_vec <= sync_s1;
            if (sync_s1 != sync_vec)
                stab_cnt <= '0;
            else if (stab_cnt != CNT_W'(DEBOUNCE_CYCLES))
                stab_cnt <= stab_cnt + CNT_W'(1);
        end
    end

    assign stable = (stab_cnt == CNT_W'(DEBOUNCE_CYCLES));

endmodule

// File: rtl/ballot_unit_ctrl.sv
// Ballot unit controller: turns an officer ballot release plus debounced
// candidate buttons into exactly one voting_en strobe per released ballot.
module ballot_unit_ctrl
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int MAX_BALLOTS     = DEFAULT_MAX_BALLOTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ballot_release,
    input  logic       close_poll,
    input  logic [2:0] cand_btn,
    output logic       voting_en,
    output logic [2:0] voter_switch,
    output logic       ready_led,
    output logic       invalid,
    output logic       timeout,
    output logic       closed,
    output logic [6:0] ballots_cast
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    ballot_state_t    state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             armed_clear;
    logic [2:0]       cand_sync;
    logic             cand_stable;
    logic             rel_s1, rel_s2, rel_d;
    logic             cls_s1, cls_s2, cls_d;
    logic             rel_rise, close_rise, at_limit;

    btn_sync_debounce #(
        .W               (3),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cand_db (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (cand_btn),
        .sync_vec (cand_sync),
        .stable   (cand_stable)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {rel_s1, rel_s2, rel_d} <= '0;
            {cls_s1, cls_s2, cls_d} <= '0;
        end else begin
            {rel_s1, rel_s2, rel_d} <= {ballot_release, rel_s1, rel_s2};
            {cls_s1, cls_s2, cls_d} <= {close_poll, cls_s1, cls_s2};
        end
    end

    assign rel_rise   = rel_s2 & ~rel_d;
    assign close_rise = cls_s2 & ~cls_d;
    assign at_limit   = (ballots_cast == 7'(MAX_BALLOTS));

    // armed_clear records that the voter has let go of every button since the
    // ballot was released, so a button held over from the previous voter
    // cannot vote.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            armed_clear  <= 1'b0;
            voting_en    <= 1'b0;
            voter_switch <= 3'b000;
            ready_led    <= 1'b0;
            invalid      <= 1'b0;
            timeout      <= 1'b0;
            closed       <= 1'b0;
            ballots_cast <= '0;
        end else begin
            voting_en    <= 1'b0;
            voter_switch <= 3'b000;
            timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    if (close_rise || at_limit) begin
                        state  <= CLOSED;
                        closed <= 1'b1;
                    end else if (rel_rise) begin
                        state       <= ARMED;
                        ready_led   <= 1'b1;
                        tmo_cnt     <= '0;
                        armed_clear <= (cand_sync == 3'b000);
                    end
                end
                ARMED: begin
                    if (close_rise) begin
                        state     <= CLOSED;
                        closed    <= 1'b1;
                        ready_led <= 1'b0;
                        invalid   <= 1'b0;
                    end else if (cand_stable && armed_clear && is_one_hot(cand_sync)) begin
                        state        <= CAST;
                        voting_en    <= 1'b1;
                        voter_switch <= cand_sync;
                        ready_led    <= 1'b0;
                        invalid      <= 1'b0;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        timeout   <= 1'b1;
                        ready_led <= 1'b0;
                        invalid   <= 1'b0;
                    end else begin
                        tmo_cnt     <= tmo_cnt + TMO_W'(1);
                        armed_clear <= armed_clear | (cand_sync == 3'b000);
                        invalid     <= cand_stable && (cand_sync != 3'b000)
                                       && !is_one_hot(cand_sync);
                    end
                end
                CAST: begin
                    if (!at_limit)
                        ballots_cast <= ballots_cast + 7'd1;
                    if (close_rise) begin
                        state  <= CLOSED;
                        closed <= 1'b1;
                    end else begin
                        state <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (close_rise) begin
                        state  <= CLOSED;
                        closed <= 1'b1;
                    end else if (cand_stable && cand_sync == 3'b000) begin
                        state <= IDLE;
                    end
                end
                CLOSED: begin
                    state <= CLOSED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ballot_unit_ctrl.sv
// Self-checking bench for ballot_unit_ctrl: directed scenarios plus randomized
// voter sessions, with a scoreboard of expected vote/timeout events.
module tb_ballot_unit_ctrl;

    localparam int DEB  = 4;
    localparam int TMO  = 20;
    localparam int MAXB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ballot_release = 1'b0;
    logic       close_poll = 1'b0;
    logic [2:0] cand_btn = 3'b000;
    logic       voting_en;
    logic [2:0] voter_switch;
    logic       ready_led;
    logic       invalid;
    logic       timeout;
    logic       closed;
    logic [6:0] ballots_cast;

    ballot_unit_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO),
        .MAX_BALLOTS     (MAXB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ballot_release (ballot_release),
        .close_poll     (close_poll),
        .cand_btn       (cand_btn),
        .voting_en      (voting_en),
        .voter_switch   (voter_switch),
        .ready_led      (ready_led),
        .invalid        (invalid),
        .timeout        (timeout),
        .closed         (closed),
        .ballots_cast   (ballots_cast)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_vote;
        logic [2:0] party;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   model_count = 0;

    logic [2:0] parties [3] = '{3'b001, 3'b010, 3'b100};
    logic [2:0] multis  [4] = '{3'b011, 3'b101, 3'b110, 3'b111};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] v, input int n);
        cand_btn = v;
        tick(n);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectVote(input logic [2:0] p);
        exp_t e;
        e.is_vote = 1'b1;
        e.party   = p;
        exp_q.push_back(e);
    endtask

    task automatic expectTimeout();
        exp_t e;
        e.is_vote = 1'b0;
        e.party   = 3'b000;
        exp_q.push_back(e);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            tick(1);
        checkOutput(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulseRelease();
        ballot_release = 1'b1;
        tick(3);
        ballot_release = 1'b0;
    endtask

    task automatic armBallot(input string name);
        pulseRelease();
        for (int i = 0; i < 10 && !ready_led; i++)
            tick(1);
        checkOutput(name, int'(ready_led), 1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        ballot_release = 1'b0;
        close_poll = 1'b0;
        cand_btn = 3'b000;
        tick(3);
        checkOutput("rst_voting_en", int'(voting_en), 0);
        checkOutput("rst_ready_led", int'(ready_led), 0);
        checkOutput("rst_closed", int'(closed), 0);
        checkOutput("rst_ballots", int'(ballots_cast), 0);
        rst = 1'b0;
        model_count = 0;
        tick(1);
    endtask

    // Every strobe or timeout pulse the DUT presents must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (voting_en || timeout) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_event: voting_en=%0b timeout=%0b switch=%b, none expected",
                             voting_en, timeout, voter_switch);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_vote != voting_en || timeout == e.is_vote
                        || (e.is_vote && voter_switch != e.party)) begin
                        bad++;
                        $display("[TB] FAIL event: got vote=%0b timeout=%0b switch=%b expected vote=%0b switch=%b",
                                 voting_en, timeout, voter_switch, e.is_vote, e.party);
                    end
                end
            end
            if (!voting_en && voter_switch != 3'b000) begin
                total++;
                bad++;
                $display("[TB] FAIL switch_idle: got %b expected 000", voter_switch);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [2:0] p;

        doReset();
        checkOutput("init_invalid", int'(invalid), 0);
        checkOutput("init_timeout", int'(timeout), 0);

        // Clean vote and press-to-strobe latency.
        armBallot("lat_arm");
        expectVote(3'b100);
        cand_btn = 3'b100;
        n = 0;
        while (!voting_en && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput("vote_latency", n, DEB + 3);
        applyStimulus(3'b100, 6);
        applyStimulus(3'b000, 10);
        waitDrain("lat_drain");
        checkOutput("lat_count", int'(ballots_cast), 1);
        checkOutput("lat_ready_after", int'(ready_led), 0);

        // Multi-press is flagged invalid, then a corrected press votes.
        armBallot("inv_arm");
        applyStimulus(3'b011, 9);
        checkOutput("inv_high", int'(invalid), 1);
        expectVote(3'b010);
        applyStimulus(3'b010, 3);
        checkOutput("inv_cleared", int'(invalid), 0);
        applyStimulus(3'b010, 6);
        applyStimulus(3'b000, 10);
        waitDrain("inv_drain");
        checkOutput("inv_count", int'(ballots_cast), 2);

        // Asynchronous reset in ARMED with a button held.
        doReset();
        armBallot("rst_arm");
        applyStimulus(3'b001, 4);
        rst = 1'b1;
        #2;
        checkOutput("async_voting_en", int'(voting_en), 0);
        checkOutput("async_switch", int'(voter_switch), 0);
        checkOutput("async_ready", int'(ready_led), 0);
        checkOutput("async_invalid", int'(invalid), 0);
        checkOutput("async_closed", int'(closed), 0);
        tick(2);
        rst = 1'b0;
        tick(15);
        checkOutput("post_rst_ready", int'(ready_led), 0);
        checkOutput("post_rst_count", int'(ballots_cast), 0);
        applyStimulus(3'b000, 6);

        // Timeout cancels the ballot; a held button must be released first.
        armBallot("tmo_arm");
        expectTimeout();
        waitDrain("tmo_drain");
        checkOutput("tmo_count", int'(ballots_cast), 0);
        checkOutput("tmo_ready", int'(ready_led), 0);
        applyStimulus(3'b010, 8);
        armBallot("carry_arm");
        applyStimulus(3'b010, 8);
        applyStimulus(3'b000, 2);
        expectVote(3'b010);
        applyStimulus(3'b010, 8);
        applyStimulus(3'b000, 10);
        waitDrain("carry_drain");
        checkOutput("carry_count", int'(ballots_cast), 1);

        // close_poll arriving in the CAST cycle still counts the vote.
        doReset();
        armBallot("cls_arm");
        expectVote(3'b001);
        applyStimulus(3'b001, 5);
        close_poll = 1'b1;
        tick(10);
        checkOutput("cls_closed", int'(closed), 1);
        checkOutput("cls_count", int'(ballots_cast), 1);
        close_poll = 1'b0;
        cand_btn = 3'b000;
        waitDrain("cls_drain");
        pulseRelease();
        tick(5);
        checkOutput("cls_locked", int'(ready_led), 0);

        // Randomized voter sessions against the event model.
        doReset();
        for (int s = 0; s < 30; s++) begin
            if (model_count == MAXB) begin
                pulseRelease();
                tick(5);
                checkOutput("lim_closed", int'(closed), 1);
                checkOutput("lim_ready", int'(ready_led), 0);
                doReset();
                continue;
            end
            armBallot("rnd_arm");
            p = parties[$urandom_range(0, 2)];
            case ($urandom_range(0, 3))
                0: begin
                    expectVote(p);
                    applyStimulus(p, $urandom_range(8, 12));
                    applyStimulus(3'b000, 10);
                    model_count++;
                end
                1: begin
                    for (int b = 0; b < 2; b++) begin
                        applyStimulus(p, $urandom_range(1, 2));
                        applyStimulus(3'b000, $urandom_range(1, 2));
                    end
                    expectVote(p);
                    applyStimulus(p, 9);
                    applyStimulus(3'b000, 10);
                    model_count++;
                end
                2: begin
                    expectTimeout();
                end
                default: begin
                    expectTimeout();
                    applyStimulus(multis[$urandom_range(0, 3)], 10);
                    checkOutput("rnd_invalid", int'(invalid), 1);
                    applyStimulus(3'b000, 3);
                end
            endcase
            waitDrain("rnd_drain");
            checkOutput("rnd_count", int'(ballots_cast), model_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
